// File: rtl/sipo_frame_controller.sv
// Receives start/data/stop framed serial words into a left-shift SIPO register
// and hands each good word to a one-entry valid/ready output buffer.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | line idle, waiting for a sampled 0 (start bit)
//   SHIFT | shifting WIDTH data bits, first bit ends up in the MSB
//   STOP  | waiting for the stop bit; 1 = deliver word, 0 = framing error
module sipo_frame_controller #(
    parameter int WIDTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_clear_n,
    input  logic                     i_bit_valid,
    input  logic                     i_bit_in,
    input  logic                     i_abort,
    output logic [WIDTH-1:0]         o_word_out,
    output logic                     o_word_valid,
    input  logic                     i_word_ready,
    output logic                     o_frame_error,
    output logic                     o_overrun,
    output logic                     o_busy,
    output logic [$clog2(WIDTH)-1:0] o_bit_count
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STOP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    r_bit_count;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_word_out;
    logic             r_word_valid;
    logic             r_frame_error;
    logic             r_overrun;
    logic             r_busy;
    logic             w_load;
    logic             w_ferr;
    logic             w_ovr;

    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort wins over a bit sampled in the same cycle and never raises an error.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_bit_count;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        w_ovr       = 1'b0;
        if (i_abort) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (i_bit_valid) begin
            case (r_state)
                IDLE: begin
                    if (!i_bit_in) begin
                        w_state_nxt = SHIFT;
                        w_cnt_nxt   = '0;
                    end
                end
                SHIFT: begin
                    w_shreg_nxt = {r_shreg[WIDTH-2:0], i_bit_in};
                    if (r_bit_count == LAST_BIT) begin
                        w_state_nxt = STOP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_bit_count + 1'b1;
                    end
                end
                STOP: begin
                    w_state_nxt = IDLE;
                    if (!i_bit_in) begin
                        w_ferr = 1'b1;
                    end else if (!r_word_valid || i_word_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_ovr = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // A load in the same cycle as an accept simply replaces the buffered word.
    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_shreg       <= '0;
            r_bit_count   <= '0;
            r_word_out    <= '0;
            r_word_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_shreg       <= w_shreg_nxt;
            r_bit_count   <= w_cnt_nxt;
            r_frame_error <= w_ferr;
            r_overrun     <= w_ovr;
            r_busy        <= (w_state_nxt != IDLE);
            if (w_load) begin
                r_word_out   <= r_shreg;
                r_word_valid <= 1'b1;
            end else if (r_word_valid && i_word_ready) begin
                r_word_valid <= 1'b0;
            end
        end
    end

    assign o_word_out    = r_word_out;
    assign o_word_valid  = r_word_valid;
    assign o_frame_error = r_frame_error;
    assign o_overrun     = r_overrun;
    assign o_busy        = r_busy;
    assign o_bit_count   = r_bit_count;

endmodule

// File: tb/tb_sipo_frame_controller.sv
// Scoreboard bench for sipo_frame_controller: a frame-level model pushes expected
// words and pulses into queues, a negedge monitor pops and compares them.
module tb_sipo_frame_controller;

    localparam int W  = 4;
    localparam int CW = $clog2(W);

    typedef struct {
        int           cyc;
        logic [W-1:0] data;
    } witem_t;

    typedef struct {
        int cyc;
        int kind;   // 0 = frame_error, 1 = overrun
    } pitem_t;

    logic          i_clk;
    logic          i_clear_n;
    logic          i_bit_valid;
    logic          i_bit_in;
    logic          i_abort;
    logic          i_word_ready;
    logic [W-1:0]  o_word_out;
    logic          o_word_valid;
    logic          o_frame_error;
    logic          o_overrun;
    logic          o_busy;
    logic [CW-1:0] o_bit_count;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    bit            mon_en  = 0;
    witem_t        wq[$];
    pitem_t        pq[$];
    int            m_pos   = -1;
    logic [W-1:0]  m_word  = '0;
    logic          exp_busy = 1'b0;
    int            exp_cnt  = 0;

    sipo_frame_controller #(.WIDTH(W)) dut (
        .i_clk         (i_clk),
        .i_clear_n     (i_clear_n),
        .i_bit_valid   (i_bit_valid),
        .i_bit_in      (i_bit_in),
        .i_abort       (i_abort),
        .o_word_out    (o_word_out),
        .o_word_valid  (o_word_valid),
        .i_word_ready  (i_word_ready),
        .o_frame_error (o_frame_error),
        .o_overrun     (o_overrun),
        .o_busy        (o_busy),
        .o_bit_count   (o_bit_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return logic'($urandom_range(0, 1));
    endfunction

    // One clock of stimulus. The model works on whole frames: count sampled bits,
    // assemble the word arithmetically, and decide the stop-bit outcome from the
    // occupancy of the expected-word queue.
    task automatic drive_cycle(input logic v, input logic b, input logic ab, input logic rdy);
        i_bit_valid  = v;
        i_bit_in     = b;
        i_abort      = ab;
        i_word_ready = rdy;
        if (ab) begin
            m_pos = -1;
        end else if (v) begin
            if (m_pos < 0) begin
                if (!b) begin
                    m_pos  = 0;
                    m_word = '0;
                end
            end else if (m_pos < W) begin
                m_word = W'((int'(m_word) * 2 + int'(b)) % (1 << W));
                m_pos++;
            end else begin
                if (!b)
                    pq.push_back('{cyc: cyc + 1, kind: 0});
                else if (wq.size() != 0 && !rdy)
                    pq.push_back('{cyc: cyc + 1, kind: 1});
                else
                    wq.push_back('{cyc: cyc + 1, data: m_word});
                m_pos = -1;
            end
        end
        @(posedge i_clk);
        #1;
        exp_busy = (m_pos >= 0);
        exp_cnt  = (m_pos < 0 || m_pos == W) ? 0 : m_pos;
    endtask

    task automatic idle(input int n, input int rmode);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b1, 1'b0, pick_ready(rmode));
    endtask

    // abort_after = k issues an abort after k frame bits (start counts as one).
    task automatic send_frame(input logic [W-1:0] data, input logic stop, input int gap,
                              input int idle1, input int rmode, input int stop_rdy,
                              input int abort_after);
        logic bits [W+2];
        bits[0] = 1'b0;
        for (int i = 0; i < W; i++) bits[1+i] = data[W-1-i];
        bits[W+1] = stop;
        for (int i = 0; i < idle1; i++) drive_cycle(1'b1, 1'b1, 1'b0, pick_ready(rmode));
        for (int k = 0; k < W + 2; k++) begin
            int g;
            logic r;
            g = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
            for (int j = 0; j < g; j++)
                drive_cycle(1'b0, logic'($urandom_range(0, 1)), 1'b0, pick_ready(rmode));
            if (abort_after == k) begin
                drive_cycle(1'b1, 1'b0, 1'b1, pick_ready(rmode));
                return;
            end
            r = (k == W + 1 && stop_rdy >= 0) ? logic'(stop_rdy) : pick_ready(rmode);
            drive_cycle(1'b1, bits[k], 1'b0, r);
        end
    endtask

    task automatic fixed_gap_frame(input logic [W-1:0] data, input int gap, input int idle1);
        logic bits [W+2];
        bits[0] = 1'b0;
        for (int i = 0; i < W; i++) bits[1+i] = data[W-1-i];
        bits[W+1] = 1'b1;
        for (int i = 0; i < idle1; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < W + 2; k++) begin
            if (k != 0) for (int j = 0; j < gap; j++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            drive_cycle(1'b1, bits[k], 1'b0, 1'b1);
        end
    endtask

    always @(negedge i_clk) begin
        if (mon_en && i_clear_n) begin
            bit ef;
            bit eo;
            bit ev;
            ef = 1'b0;
            eo = 1'b0;
            if (pq.size() > 0 && pq[0].cyc <= cyc) begin
                if (pq[0].cyc < cyc) chk("pulse_late", 32'(pq[0].cyc), 32'(cyc));
                ef = (pq[0].kind == 0);
                eo = (pq[0].kind == 1);
                void'(pq.pop_front());
            end
            if (o_frame_error || ef) chk("frame_error", 32'(o_frame_error), 32'(ef));
            if (o_overrun || eo)     chk("overrun", 32'(o_overrun), 32'(eo));
            ev = (wq.size() > 0 && wq[0].cyc <= cyc);
            chk("word_valid", 32'(o_word_valid), 32'(ev));
            if (ev && o_word_valid) chk("word_out", 32'(o_word_out), 32'(wq[0].data));
            if (o_word_valid && i_word_ready && wq.size() > 0) void'(wq.pop_front());
            chk("busy", 32'(o_busy), 32'(exp_busy));
            chk("bit_count", 32'(o_bit_count), 32'(exp_cnt));
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_word_valid"}, 32'(o_word_valid), 32'd0);
        chk({tag, "_word_out"}, 32'(o_word_out), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_bit_count"}, 32'(o_bit_count), 32'd0);
        chk({tag, "_frame_error"}, 32'(o_frame_error), 32'd0);
        chk({tag, "_overrun"}, 32'(o_overrun), 32'd0);
    endtask

    initial begin
        i_clear_n    = 1'b0;
        i_bit_valid  = 1'b0;
        i_bit_in     = 1'b1;
        i_abort      = 1'b0;
        i_word_ready = 1'b1;
        #1;
        check_all_zero("reset");
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_clear_n = 1'b1;
        mon_en    = 1'b1;
        idle(2, 1);

        // 1: back-to-back bits, consumer always ready
        send_frame(4'b1011, 1'b1, 0, 0, 1, -1, -1);
        idle(3, 1);
        // 2: gaps of 3 cycles and idle ones before the start bit
        fixed_gap_frame(4'b1011, 3, 3);
        idle(3, 1);
        // 3: bad stop bit, then a good frame
        send_frame(4'b1100, 1'b0, 0, 0, 1, -1, -1);
        send_frame(4'b0110, 1'b1, 0, 0, 1, -1, -1);
        idle(3, 1);
        // 4: buffer full, second word dropped with overrun
        send_frame(4'b1001, 1'b1, 0, 0, 0, -1, -1);
        send_frame(4'b0111, 1'b1, 0, 0, 0, -1, -1);
        idle(2, 0);
        idle(3, 1);
        // 5: load coincides with accept
        send_frame(4'b1001, 1'b1, 0, 0, 0, -1, -1);
        send_frame(4'b0111, 1'b1, 0, 0, 0, 1, -1);
        idle(2, 0);
        idle(3, 1);
        // 6a: abort after two data bits, sampled bit ignored
        send_frame(4'b1010, 1'b1, 0, 0, 1, -1, 3);
        idle(3, 1);
        send_frame(4'b0101, 1'b1, 1, 0, 1, -1, -1);
        idle(3, 1);
        // 6b: async clear mid-frame with a word buffered
        send_frame(4'b1110, 1'b1, 0, 0, 0, -1, -1);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        i_clear_n = 1'b0;
        wq.delete();
        pq.delete();
        m_pos    = -1;
        exp_busy = 1'b0;
        exp_cnt  = 0;
        #1;
        check_all_zero("clear");
        @(posedge i_clk);
        #1;
        i_clear_n = 1'b1;
        send_frame(4'b0011, 1'b1, 0, 0, 1, -1, -1);
        idle(3, 1);

        // randomized frames with random gaps, ready, bad stops and aborts
        for (int f = 0; f < 80; f++) begin
            logic [W-1:0] d;
            logic         s;
            int           ab;
            d  = W'($urandom_range(0, (1 << W) - 1));
            s  = ($urandom_range(0, 9) != 0);
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, W + 1)) : -1;
            send_frame(d, s, $urandom_range(0, 3), $urandom_range(0, 2), 2, -1, ab);
        end

        idle(6, 1);
        chk("words_left", 32'(wq.size()), 32'd0);
        chk("pulses_left", 32'(pq.size()), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_frame_controller.md
Name: sipo_frame_controller

Overview:
Sequences a WIDTH-bit left-shift SIPO register to receive start/data/stop framed serial words. Detects the start bit, counts data bits and checks the stop bit. Each completed word goes into a one-entry output buffer with a valid/ready handshake. Sits between a serial bit source and a parallel word consumer.

Parameters:
WIDTH, 4, number of data bits per frame (>= 2); the first data bit received lands in the MSB.

Ports:
clk  input  1  rising-edge clock
clear_n  input  1  reset, asynchronous, active-low
bit_valid  input  1  bit_in is sampled on this edge
bit_in  input  1  serial data; line idles high
abort  input  1  synchronous; drops any frame in progress
word_out  output  WIDTH  buffered parallel word
word_valid  output  1  word_out holds an unconsumed word
word_ready  input  1  consumer accepts word_out when word_valid is high
frame_error  output  1  one-cycle pulse: stop bit was 0
overrun  output  1  one-cycle pulse: good word dropped because the buffer was full
busy  output  1  high when state is not IDLE
bit_count  output  clog2(WIDTH)  data bits shifted in the current frame (debug)

Behaviour:
- Reset (clear_n=0, asynchronous): state=IDLE; shift register=0; bit_count=0; word_out=0; word_valid=0; frame_error=0; overrun=0; busy=0.
- Cycles with bit_valid=0: state, shift register and bit_count hold.
- All outputs are registered.
- IDLE:
  - bit_valid & bit_in=0 (start bit): go to SHIFT; bit_count=0.
  - bit_valid & bit_in=1: ignored.
- SHIFT, on each bit_valid:
  - shreg <= {shreg[WIDTH-2:0], bit_in}.
  - If bit_count == WIDTH-1: go to STOP and set bit_count=0.
  - Otherwise bit_count increments.
- STOP, on bit_valid (always returns to IDLE):
  - bit_in=1 and (word_valid=0 or word_ready=1 this cycle): word_out <= shreg; word_valid=1 on the next cycle (1-cycle latency after the stop-bit edge).
  - bit_in=1 and word_valid=1 and word_ready=0: overrun pulses 1 cycle; new word discarded; word_out and word_valid unchanged.
  - bit_in=0: frame_error pulses 1 cycle; word discarded; output buffer unchanged.
- Handshake:
  - word_valid=1 & word_ready=1 with no load in the same cycle: word_valid clears next cycle.
  - While word_valid=1, word_out stays stable until accepted.
  - A load and an accept in the same cycle: new word replaces the old one, word_valid stays 1, no overrun.
- Back-to-back frames: a start bit may be sampled on the cycle right after the stop bit.
- abort=1: state -> IDLE and bit_count=0 next cycle; abort has priority over bit_valid in that cycle. The shift register contents are don't-care. The output buffer, word_valid and the handshake are unaffected. No error pulse.
- clear_n asserted mid-frame or with a buffered word: everything returns to reset values at once; the partial frame and the buffered word are lost.
- frame_error and overrun never assert in the same cycle.

Test Plan:
1. WIDTH=4, word_ready=1. Bits 0(start),1,0,1,1,1(stop) on consecutive cycles -> word_out=4'b1011 and word_valid=1 one cycle after the stop edge; busy low after the stop edge; word_valid clears one cycle later.
2. Same frame with bit_valid low for 3 cycles between each bit, plus idle 1s before the start bit -> identical result, 4'b1011; the idle 1s are ignored.
3. Frame 0,1,1,0,0 with stop bit 0 -> frame_error pulses for exactly 1 cycle; word_valid stays 0; the next good frame 0,0,1,1,0,1 gives word_out=4'b0110.
4. word_ready=0; frame A=4'b1001 then frame B=4'b0111 -> word_out stays 4'b1001, overrun pulses once at B's stop. Then word_ready=1 -> word_valid clears.
5. Word 4'b1001 buffered; a second frame 4'b0111 whose stop-bit cycle coincides with word_ready=1 -> no overrun; word_out=4'b0111 and word_valid stays 1.
6. After 2 data bits: pulse abort -> busy=0 next cycle, no output. Repeat, but drive clear_n=0 asynchronously mid-frame with a word buffered -> all outputs 0 immediately; a following full frame decodes correctly.
